// File: rtl/eluks_byte_server.sv
// ---------------------------------------------------------------------------
// eluks_byte_server
//
// Byte-granular read responder for the encrypted-volume read path. A reader
// task asks for one byte at a time; this block serves them from an internal
// block buffer. It fetches whole SD blocks through the SPI block interface and
// automatically fetches the next sequential block once the current one has
// been consumed.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   start          pulse: begin streaming at base_addr (honoured only in IDLE)
//   base_addr      first block address, sampled on an accepted start
//   r_byte         byte request pulse (honoured only when busy=0 and ready=1)
//   data_out       served byte, held until the next accepted request
//   busy           request in progress / refilling / error
//   ready          buffer holds unserved bytes
//   r_block        one-cycle block read command to the SPI controller
//   block_addr     block address for r_block, stable through the fill
//   spi_busy       SPI controller busy
//   spi_data       byte from the SPI controller
//   spi_data_valid spi_data valid this cycle
//   bytes_served   bytes delivered since start (wraps mod 2^32)
//   error          sticky error flag (timeout, overrun or short block)
// ---------------------------------------------------------------------------
module eluks_byte_server #(
    parameter int BLOCK_BYTES    = 512,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        r_byte,
    output logic [7:0]  data_out,
    output logic        busy,
    output logic        ready,
    output logic        r_block,
    output logic [31:0] block_addr,
    input  logic        spi_busy,
    input  logic [7:0]  spi_data,
    input  logic        spi_data_valid,
    output logic [31:0] bytes_served,
    output logic        error
);

    localparam int IDX_W = $clog2(BLOCK_BYTES);
    // The write index must be able to hold BLOCK_BYTES itself (block full).
    localparam int CNT_W = IDX_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(BLOCK_BYTES);
    localparam logic [IDX_W-1:0] RD_LAST   = IDX_W'(BLOCK_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_SPI,
        S_FILL,
        S_SERVE,
        S_ERROR
    } state_t;

    state_t            state_reg;
    logic [31:0]       cur_addr_reg;
    logic [CNT_W-1:0]  wr_idx_reg;
    logic [IDX_W-1:0]  rd_idx_reg;
    logic [TO_W-1:0]   timeout_reg;
    logic [7:0]        data_out_reg;
    logic              busy_reg;
    logic              ready_reg;
    logic              r_block_reg;
    logic [31:0]       block_addr_reg;
    logic [31:0]       bytes_served_reg;
    logic              error_reg;

    // Block buffer: written only in FILL, read only in SERVE.
    logic [7:0] buffer [BLOCK_BYTES];

    logic              wr_full;
    logic              buf_we;
    logic [CNT_W-1:0]  fill_count;
    logic              fill_overrun;
    logic              fill_short;
    logic              wait_expired;
    logic              to_error;
    logic              accept;

    always_comb begin
        wr_full      = (wr_idx_reg == FILL_FULL);
        buf_we       = (state_reg == S_FILL) && spi_data_valid && !wr_full;
        // A byte arriving in the same cycle spi_busy falls still counts.
        fill_count   = wr_idx_reg + CNT_W'(buf_we);
        fill_overrun = (state_reg == S_FILL) && spi_data_valid && wr_full;
        fill_short   = (state_reg == S_FILL) && !fill_overrun && !spi_busy
                       && (fill_count != FILL_FULL);
        wait_expired = (state_reg == S_WAIT_SPI) && !spi_busy
                       && (timeout_reg == TO_LAST);
        to_error     = fill_overrun || fill_short || wait_expired;
        // busy_reg is high in SERVE only during the response cycle.
        accept       = (state_reg == S_SERVE) && r_byte && !busy_reg;
    end

    // Buffer write port kept reset-free so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buffer[wr_idx_reg[IDX_W-1:0]] <= spi_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= S_IDLE;
            cur_addr_reg     <= '0;
            wr_idx_reg       <= '0;
            rd_idx_reg       <= '0;
            timeout_reg      <= '0;
            data_out_reg     <= '0;
            busy_reg         <= 1'b0;
            ready_reg        <= 1'b0;
            r_block_reg      <= 1'b0;
            block_addr_reg   <= '0;
            bytes_served_reg <= '0;
            error_reg        <= 1'b0;
        end else begin
            // r_block is a single-cycle pulse, only raised on entry to LOAD.
            r_block_reg <= 1'b0;

            if (to_error) begin
                state_reg <= S_ERROR;
                error_reg <= 1'b1;
                busy_reg  <= 1'b1;
                ready_reg <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (start) begin
                            cur_addr_reg     <= base_addr;
                            block_addr_reg   <= base_addr;
                            bytes_served_reg <= '0;
                            r_block_reg      <= 1'b1;
                            busy_reg         <= 1'b1;
                            state_reg        <= S_LOAD;
                        end
                    end

                    S_LOAD: begin
                        wr_idx_reg  <= '0;
                        timeout_reg <= '0;
                        state_reg   <= S_WAIT_SPI;
                    end

                    S_WAIT_SPI: begin
                        if (spi_busy) begin
                            state_reg <= S_FILL;
                        end else begin
                            timeout_reg <= timeout_reg + TO_W'(1);
                        end
                    end

                    S_FILL: begin
                        if (buf_we) begin
                            wr_idx_reg <= wr_idx_reg + CNT_W'(1);
                        end
                        // Short blocks were diverted to ERROR above.
                        if (!spi_busy) begin
                            rd_idx_reg   <= '0;
                            cur_addr_reg <= cur_addr_reg + 32'd1;
                            ready_reg    <= 1'b1;
                            busy_reg     <= 1'b0;
                            state_reg    <= S_SERVE;
                        end
                    end

                    S_SERVE: begin
                        if (busy_reg) begin
                            busy_reg <= 1'b0;
                        end else if (accept) begin
                            data_out_reg     <= buffer[rd_idx_reg];
                            rd_idx_reg       <= rd_idx_reg + IDX_W'(1);
                            bytes_served_reg <= bytes_served_reg + 32'd1;
                            busy_reg         <= 1'b1;
                            if (rd_idx_reg == RD_LAST) begin
                                // Last byte of the block: refill straight
                                // away; busy stays high until SERVE again.
                                ready_reg      <= 1'b0;
                                r_block_reg    <= 1'b1;
                                block_addr_reg <= cur_addr_reg;
                                state_reg      <= S_LOAD;
                            end
                        end
                    end

                    S_ERROR: begin
                        error_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                        ready_reg <= 1'b0;
                    end

                    default: begin
                        state_reg <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign data_out     = data_out_reg;
    assign busy         = busy_reg;
    assign ready        = ready_reg;
    assign r_block      = r_block_reg;
    assign block_addr   = block_addr_reg;
    assign bytes_served = bytes_served_reg;
    assign error        = error_reg;

endmodule

// File: tb/tb_eluks_byte_server.sv
module tb_eluks_byte_server;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic        r_byte;
    logic [7:0]  data_out;
    logic        busy;
    logic        ready;
    logic        r_block;
    logic [31:0] block_addr;
    logic        spi_busy;
    logic [7:0]  spi_data;
    logic        spi_data_valid;
    logic [31:0] bytes_served;
    logic        error;

    always #5 clk = ~clk;

    eluks_byte_server #(
        .BLOCK_BYTES    (512),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .base_addr      (base_addr),
        .r_byte         (r_byte),
        .data_out       (data_out),
        .busy           (busy),
        .ready          (ready),
        .r_block        (r_block),
        .block_addr     (block_addr),
        .spi_busy       (spi_busy),
        .spi_data       (spi_data),
        .spi_data_valid (spi_data_valid),
        .bytes_served   (bytes_served),
        .error          (error)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_reads  = 0;

    logic [7:0]  exp_q  [$];
    logic [31:0] addr_q [$];

    // SPI model controls
    int          spi_count  = 512;
    logic [7:0]  spi_seed   = 8'h00;
    bit          spi_silent = 1'b0;
    bit          spi_hold   = 1'b0;
    int          spi_sent   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    // Data monitor: every accepted request must match the next expected byte.
    initial begin : data_monitor
        logic [7:0] e;
        forever begin
            @(posedge clk);
            if (rst_n && r_byte && !busy && ready) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    check("unexpected_accept", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    n_reads++;
                    check("read_data", 32'(data_out), 32'(e));
                    check("resp_busy", 32'(busy), 32'd1);
                    $display("read %0d: data=0x%02h expected=0x%02h served=%0d",
                             n_reads, data_out, e, bytes_served);
                end
            end
        end
    end

    // Block command monitor: each r_block pulse must match the next address.
    initial begin : addr_monitor
        forever begin
            @(negedge clk);
            if (r_block) begin
                if (addr_q.size() == 0) begin
                    check("unexpected_r_block", 32'd1, 32'd0);
                end else begin
                    check("block_addr", block_addr, addr_q.pop_front());
                    $display("r_block: addr=0x%08h", block_addr);
                end
            end
        end
    end

    // SPI controller model: after r_block, raise spi_busy, stream spi_count
    // bytes (seed+i) with occasional gaps, dropping busy with the last byte.
    initial begin : spi_model
        spi_busy = 1'b0; spi_data_valid = 1'b0; spi_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!spi_hold) spi_busy = 1'b0;
            if (r_block && !spi_silent) begin
                spi_sent = 0;
                repeat (2) @(negedge clk);
                spi_busy = 1'b1;
                @(negedge clk);
                for (int i = 0; i < spi_count; i++) begin
                    spi_data = spi_seed + 8'(i);
                    spi_data_valid = 1'b1;
                    spi_sent++;
                    if (i == spi_count - 1 && !spi_hold) spi_busy = 1'b0;
                    @(negedge clk);
                    if (i % 5 == 4) begin
                        spi_data_valid = 1'b0;
                        @(negedge clk);
                    end
                end
                spi_data_valid = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_stream(input logic [31:0] addr);
        base_addr = addr;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_serve(input string name);
        int n = 0;
        while (!(ready && !busy) && n < 5000) begin @(negedge clk); n++; end
        check(name, 32'(ready && !busy), 32'd1);
    endtask

    task automatic wait_error(input string name);
        int n = 0;
        while (!error && n < 5000) begin @(negedge clk); n++; end
        check(name, 32'(error), 32'd1);
    endtask

    task automatic read_byte(input logic [7:0] e);
        int n = 0;
        while (!(ready && !busy) && n < 5000) begin @(negedge clk); n++; end
        if (n >= 5000) begin
            check("read_wait_timeout", 32'd0, 32'd1);
            return;
        end
        exp_q.push_back(e);
        r_byte = 1'b1;
        @(negedge clk);
        r_byte = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},         32'(busy), 32'd0);
        check({tag, "_ready"},        32'(ready), 32'd0);
        check({tag, "_r_block"},      32'(r_block), 32'd0);
        check({tag, "_block_addr"},   block_addr, 32'd0);
        check({tag, "_data_out"},     32'(data_out), 32'd0);
        check({tag, "_bytes_served"}, bytes_served, 32'd0);
        check({tag, "_error"},        32'(error), 32'd0);
    endtask

    initial begin : main
        int bad;
        int n;
        rst_n = 1'b0; start = 1'b0; base_addr = 32'd0; r_byte = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // r_byte in IDLE is ignored
        r_byte = 1'b1; @(negedge clk); r_byte = 1'b0; @(negedge clk);
        check("idle_rbyte_served", bytes_served, 32'd0);
        check("idle_rbyte_busy", 32'(busy), 32'd0);

        // Full block at 0x10: bytes 0x00..0xFF twice
        spi_count = 512; spi_seed = 8'h00;
        addr_q.push_back(32'h0000_0010);
        start_stream(32'h0000_0010);
        wait_serve("fill1_ready");
        check("fill1_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 512; i++) begin
            if (i == 511) begin
                spi_seed = 8'h40;
                addr_q.push_back(32'h0000_0011);
            end
            read_byte(8'(i));
        end
        check("served_512", bytes_served, 32'd512);

        // Refill: busy must stay high until the buffer is ready again
        bad = 0; n = 0;
        while (!ready && n < 5000) begin
            if (!busy) bad++;
            @(negedge clk); n++;
        end
        check("refill_busy_held", 32'(bad), 32'd0);
        check("refill_ready", 32'(ready), 32'd1);
        read_byte(8'h40);
        check("served_513", bytes_served, 32'd513);

        // r_byte held three cycles: first and third edges accepted
        wait_serve("hold_ready");
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        r_byte = 1'b1;
        repeat (3) @(negedge clk);
        r_byte = 1'b0;
        @(negedge clk);
        check("hold_served", bytes_served, 32'd515);
        read_byte(8'h43);
        check("served_516", bytes_served, 32'd516);

        // Timeout: SPI never raises busy
        do_reset();
        spi_silent = 1'b1;
        addr_q.push_back(32'h0000_0100);
        start_stream(32'h0000_0100);
        repeat (16) @(negedge clk);
        check("timeout_not_yet", 32'(error), 32'd0);
        @(negedge clk);
        check("timeout_error", 32'(error), 32'd1);
        check("timeout_busy", 32'(busy), 32'd1);
        check("timeout_ready", 32'(ready), 32'd0);
        start_stream(32'h0000_0200);
        repeat (20) @(negedge clk);
        check("error_sticky", 32'(error), 32'd1);
        check("error_start_ignored", 32'(r_block), 32'd0);
        spi_silent = 1'b0;

        // Short block: 511 bytes
        do_reset();
        spi_count = 511; spi_seed = 8'h00;
        addr_q.push_back(32'h0000_0020);
        start_stream(32'h0000_0020);
        wait_error("short_error");
        check("short_ready", 32'(ready), 32'd0);
        check("short_busy", 32'(busy), 32'd1);

        // Overrun: 513 bytes
        do_reset();
        spi_count = 513;
        addr_q.push_back(32'h0000_0021);
        start_stream(32'h0000_0021);
        wait_error("overrun_error");
        check("overrun_ready", 32'(ready), 32'd0);

        // Reset in the middle of a fill
        do_reset();
        spi_count = 200; spi_hold = 1'b1;
        addr_q.push_back(32'h0000_0030);
        start_stream(32'h0000_0030);
        n = 0;
        while (spi_sent != 200 && n < 5000) begin @(negedge clk); n++; end
        check("midfill_reached", 32'(spi_sent), 32'd200);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        spi_hold = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Address wrap 0xFFFFFFFF -> 0x00000000
        spi_count = 512; spi_seed = 8'h80;
        addr_q.push_back(32'hFFFF_FFFF);
        start_stream(32'hFFFF_FFFF);
        wait_serve("wrap_ready");
        for (int i = 0; i < 512; i++) begin
            if (i == 511) begin
                spi_seed = 8'hC0;
                addr_q.push_back(32'h0000_0000);
            end
            read_byte(8'h80 + 8'(i));
        end
        check("wrap_served_512", bytes_served, 32'd512);
        read_byte(8'hC0);
        check("wrap_served_513", bytes_served, 32'd513);

        repeat (5) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("addr_q_drained", 32'(addr_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
